// File: rtl/tpu_host_sequencer_if.sv
// rtl/tpu_host_sequencer_if.sv - Avalon-MM bus between the host sequencer and the TPU slave wrapper
interface tpu_host_sequencer_if #(
    parameter int DATA_WIDTH = 64
);
    logic [9:0]              address;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/tpu_host_sequencer.sv
// rtl/tpu_host_sequencer.sv - Avalon-MM master running one full matrix-multiply job on the TPU slave
module tpu_host_sequencer #(
    parameter int DATA_WIDTH   = 64,
    parameter int WIDTH_HEIGHT = 16,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            job_w_base,
    input  logic [7:0]            job_in_base,
    input  logic [7:0]            job_out_base,
    input  logic [7:0]            job_in_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    tpu_host_sequencer_if.master  master
);
    localparam int PW = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, RST_CMD, LOAD_W, FILL_CMD, POLL_FILL, DRAIN_CMD, POLL_DRAIN,
        LOAD_IN, MUL_CMD, POLL_OUT, READ_OUT, DONE, ERROR
    } state_t;

    state_t                state;
    state_t                cmd_next;
    state_t                poll_next;
    state_t                load_next;
    logic [7:0]            w_base;
    logic [7:0]            in_base;
    logic [7:0]            out_base;
    logic [7:0]            in_rows;
    logic [8:0]            cnt;
    logic [PW-1:0]         poll_cnt;
    logic                  pending;
    logic [DATA_WIDTH-1:0] cmd_word;
    logic                  poll_bit;
    logic [7:0]            row;
    logic                  last;

    assign master.byteenable = '1;

    // Per-state command word, status bit, row address and successor state.
    always_comb begin
        cmd_word  = '0;
        cmd_next  = IDLE;
        poll_bit  = 1'b0;
        poll_next = IDLE;
        load_next = IDLE;
        row       = '0;
        last      = 1'b0;
        case (state)
            RST_CMD: begin
                cmd_word = DATA_WIDTH'(4'hF);
                cmd_next = LOAD_W;
            end
            FILL_CMD: begin
                cmd_word = DATA_WIDTH'({w_base, 4'h1});
                cmd_next = POLL_FILL;
            end
            DRAIN_CMD: begin
                cmd_word = DATA_WIDTH'(4'h2);
                cmd_next = POLL_DRAIN;
            end
            MUL_CMD: begin
                cmd_word = DATA_WIDTH'({out_base, in_base, 4'h3});
                cmd_next = POLL_OUT;
            end
            POLL_FILL: begin
                poll_bit  = master.readdata[0];
                poll_next = DRAIN_CMD;
            end
            POLL_DRAIN: begin
                poll_bit  = master.readdata[1];
                poll_next = LOAD_IN;
            end
            POLL_OUT: begin
                poll_bit  = master.readdata[2];
                poll_next = READ_OUT;
            end
            LOAD_W: begin
                row       = w_base + cnt[7:0];
                last      = (cnt == 9'(WIDTH_HEIGHT - 1));
                load_next = FILL_CMD;
            end
            LOAD_IN: begin
                row       = in_base + cnt[7:0];
                last      = (cnt == {1'b0, in_rows});
                load_next = MUL_CMD;
            end
            READ_OUT: begin
                row  = out_base + cnt[7:0];
                last = (cnt == {1'b0, in_rows});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            wr_ready         <= 1'b0;
            rd_valid         <= 1'b0;
            rd_data          <= '0;
            master.address   <= '0;
            master.read      <= 1'b0;
            master.write     <= 1'b0;
            master.writedata <= '0;
            w_base           <= '0;
            in_base          <= '0;
            out_base         <= '0;
            in_rows          <= '0;
            cnt              <= '0;
            poll_cnt         <= '0;
            pending          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_base   <= job_w_base;
                        in_base  <= job_in_base;
                        out_base <= job_out_base;
                        in_rows  <= job_in_rows;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RST_CMD;
                    end
                end
                RST_CMD, FILL_CMD, DRAIN_CMD, MUL_CMD: begin
                    if (!master.write) begin
                        master.write     <= 1'b1;
                        master.address   <= '0;
                        master.writedata <= cmd_word;
                    end else if (!master.waitrequest) begin
                        master.write <= 1'b0;
                        state        <= cmd_next;
                        cnt          <= '0;
                        poll_cnt     <= '0;
                        wr_ready     <= (state == RST_CMD);
                    end
                end
                LOAD_W, LOAD_IN: begin
                    // wr_ready is only high while no write is in flight, so a word lands directly on the bus.
                    if (wr_ready && wr_valid) begin
                        wr_ready         <= 1'b0;
                        master.write     <= 1'b1;
                        master.address   <= {2'b01, row};
                        master.writedata <= wr_data;
                    end else if (master.write && !master.waitrequest) begin
                        master.write <= 1'b0;
                        if (last) begin
                            state <= load_next;
                        end else begin
                            cnt      <= cnt + 9'd1;
                            wr_ready <= 1'b1;
                        end
                    end
                end
                POLL_FILL, POLL_DRAIN, POLL_OUT: begin
                    if (master.read) begin
                        if (!master.waitrequest) begin
                            master.read <= 1'b0;
                            pending     <= 1'b1;
                        end
                    end else if (pending) begin
                        if (master.readdatavalid) begin
                            pending <= 1'b0;
                            if (poll_bit) begin
                                state    <= poll_next;
                                cnt      <= '0;
                                wr_ready <= (state == POLL_DRAIN);
                            end else if (poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
                                state <= ERROR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                poll_cnt <= poll_cnt + PW'(1);
                            end
                        end
                    end else begin
                        master.read    <= 1'b1;
                        master.address <= '0;
                    end
                end
                READ_OUT: begin
                    // Next result read waits until the previous word has left on the stream.
                    if (master.read) begin
                        if (!master.waitrequest) begin
                            master.read <= 1'b0;
                            pending     <= 1'b1;
                        end
                    end else if (pending) begin
                        if (master.readdatavalid) begin
                            pending  <= 1'b0;
                            rd_data  <= master.readdata;
                            rd_valid <= 1'b1;
                        end
                    end else if (rd_valid) begin
                        if (rd_ready) begin
                            rd_valid <= 1'b0;
                            if (last) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                cnt <= cnt + 9'd1;
                            end
                        end
                    end else begin
                        master.read    <= 1'b1;
                        master.address <= {2'b11, row};
                    end
                end
                DONE:    state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
